rad_monitor_record_packer: RTL and testbench
============================================

RAD_MONITOR_RECORD_PACKER -- requirements
Module: rad_monitor_record_packer

Interface
REQ-001 The module SHALL have parameter G_MODULES_CONNECTED, default 5, meaning the number of monitored modules; legal range is 1..255.
REQ-002 The module SHALL have parameter G_ADDITIONAL_MISMATCH, default 1, meaning 1 = 5-byte records and 0 = 3-byte records.
REQ-003 The module SHALL have clk_i, input, 1 bit: the single clock.
REQ-004 The module SHALL have rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have fifo_empty_i, input, 1 bit: upstream first-word-fall-through FIFO empty flag.
REQ-006 The module SHALL have fifo_read_o, output, 1 bit: pops one byte from the upstream FIFO.
REQ-007 The module SHALL have fifo_data_i, input, 8 bits: FIFO head byte, valid while fifo_empty_i=0.
REQ-008 The module SHALL have rec_valid_o, output, 1 bit: an assembled record is available.
REQ-009 The module SHALL have rec_ready_i, input, 1 bit: the downstream consumer accepts the record.
REQ-010 The module SHALL have rec_data_o, output, 40 bits: {module[39:32], value[31:24], cnt[23:16], value2[15:8], cnt2[7:0]}.
REQ-011 The module SHALL have sync_error_o, output, 1 bit: one-cycle pulse on a framing error.
REQ-012 The module SHALL have sync_error_cnt_o, output, 16 bits: framing error count, saturating at 0xFFFF.

Function
REQ-013 The FSM SHALL have states ADDR, VALUE, CNT, VALUE2, CNT2 and OUT; state encoding is free, and illegal states SHALL return to ADDR with the lock cleared.
REQ-014 In the collection states (ADDR through CNT2), fifo_read_o SHALL equal !fifo_empty_i combinationally; in OUT it SHALL be 0.
REQ-015 A byte SHALL be consumed only in a cycle where fifo_read_o=1; while the FIFO is empty the FSM SHALL hold its state.
REQ-016 Transition sequence: ADDR->VALUE->CNT->OUT when G_ADDITIONAL_MISMATCH=0.
REQ-017 Transition sequence: ADDR->VALUE->CNT->VALUE2->CNT2->OUT when G_ADDITIONAL_MISMATCH=1.
REQ-018 When G_ADDITIONAL_MISMATCH=0, rec_data_o[15:0] SHALL be 0.
REQ-019 Lock rule: when unlocked, ADDR SHALL accept any byte < G_MODULES_CONNECTED; when locked, ADDR SHALL accept only the byte equal to expected_module.
REQ-020 A rejected address byte SHALL be popped and discarded, SHALL clear the lock, SHALL pulse sync_error_o in the following cycle, SHALL increment sync_error_cnt_o (saturating), and the FSM SHALL stay in ADDR.
REQ-021 When a record's last byte is consumed, the lock SHALL be set.
REQ-022 When a record's last byte is consumed, expected_module SHALL become (module+1), wrapping to 0 at G_MODULES_CONNECTED.
REQ-023 In OUT, rec_valid_o SHALL be 1 (registered), asserted in the cycle after the last byte is popped.
REQ-024 While rec_valid_o=1 and rec_ready_i=0, rec_data_o SHALL be held stable.
REQ-025 The record SHALL transfer when rec_valid_o and rec_ready_i are both 1; the FSM SHALL then go to ADDR with rec_valid_o=0 in the next cycle.
REQ-026 Minimum record period SHALL be N+1 cycles (N = record bytes), with no back-to-back OUT cycles.
REQ-027 Counter bytes SHALL be passed through unmodified; 8-bit counter wrap-around (0xFF->0x00) SHALL NOT be treated as an error.

Reset
REQ-028 On rst_n_i=0, outputs SHALL reset asynchronously: fifo_read_o=0, rec_valid_o=0, rec_data_o=0, sync_error_o=0, sync_error_cnt_o=0.
REQ-029 On rst_n_i=0, internal state SHALL reset to: state=ADDR, unlocked, expected_module=0, filter memory cleared.
REQ-030 Deassertion of rst_n_i SHALL be synchronised to clk_i via a 2-flop synchroniser.
REQ-031 Reset asserted mid-record or in OUT SHALL discard the partial or pending record.

Configuration
REQ-032 Macro RAD_PACKER_CHANGE_FILTER_EN SHALL control the change filter.
REQ-033 With the macro defined, per module the block SHALL keep a last-forwarded {cnt,cnt2} value and a seen flag.
REQ-034 With the macro defined, a completed record whose seen flag is 1 and whose {cnt,cnt2} equals the stored value SHALL be dropped: no OUT and no rec_valid_o; the FSM SHALL go straight to ADDR, with lock and expected_module still updated.
REQ-035 With the macro defined, every other record SHALL go to OUT and SHALL update the stored value and seen flag on transfer.
REQ-036 Without the macro, the block SHALL contain no filter storage and SHALL forward every record.

Verification
REQ-037 Reset, then feed bytes 00,11,01,22,02 (G_ADDITIONAL_MISMATCH=1) with rec_ready_i=1 -> one record 0x0011012202, rec_valid_o for exactly 1 cycle, sync_error_cnt_o=0.
REQ-038 Feed records for modules 0 then 2 (module 1 skipped) -> module-2 address rejected, sync_error_o pulses once, count=1; the next in-range address relocks and its record is output.
REQ-039 Hold rec_ready_i=0 for 10 cycles with a record pending and the FIFO non-empty -> rec_data_o stable, fifo_read_o=0 throughout; transfer on the first ready cycle.
REQ-040 Send modules 0..4 then 0 with fifo_empty_i toggling every other cycle -> 6 correct records, expected_module wraps 4->0 with no error.
REQ-041 With RAD_PACKER_CHANGE_FILTER_EN, send module 3 cnt=05 twice then cnt=06 -> records 1 and 3 forwarded, record 2 dropped; without the macro -> all 3 forwarded.
REQ-042 Assert rst_n_i after the 3rd byte of a record -> outputs reset immediately; the next full record is received cleanly with no stale bytes.

Source files
------------

// File: rtl/rad_monitor_record_packer.sv
// rad_monitor_record_packer: packs FIFO bytes into 3/5-byte monitor records and tracks the module address sequence.
// Defining RAD_PACKER_CHANGE_FILTER_EN drops records whose counters repeat the last forwarded value for that module.
module rad_monitor_record_packer #(
   parameter int G_MODULES_CONNECTED   = 5,
   parameter int G_ADDITIONAL_MISMATCH = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        fifo_empty_i,
   output logic        fifo_read_o,
   input  logic [7:0]  fifo_data_i,
   output logic        rec_valid_o,
   input  logic        rec_ready_i,
   output logic [39:0] rec_data_o,
   output logic        sync_error_o,
   output logic [15:0] sync_error_cnt_o
);
   localparam logic [7:0] NMOD = 8'(G_MODULES_CONNECTED);
   localparam bit TWO_MM = G_ADDITIONAL_MISMATCH != 0;
   typedef enum logic [2:0] {ADDR, VALUE, CNT, VALUE2, CNT2, OUT} state_t;
   state_t state;
   logic [1:0] rst_sync;
   logic rst_n, locked, coll, addr_ok, last_byte, drop;
   logic [7:0] expected_module, cur_mod, next_mod;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) rst_sync <= 2'b00;
      else rst_sync <= {rst_sync[0], 1'b1};
   assign rst_n = rst_sync[1];
   assign coll = state inside {ADDR, VALUE, CNT, VALUE2, CNT2};
   assign fifo_read_o = rst_n && coll && !fifo_empty_i;
   assign addr_ok = locked ? fifo_data_i == expected_module : fifo_data_i < NMOD;
   assign last_byte = state == CNT2 || (state == CNT && !TWO_MM);
   // the module byte lives in rec_data_o from the moment the address is accepted
   assign cur_mod = rec_data_o[39:32];
   assign next_mod = cur_mod == NMOD - 8'd1 ? 8'd0 : cur_mod + 8'd1;
`ifdef RAD_PACKER_CHANGE_FILTER_EN
   localparam int MW = G_MODULES_CONNECTED > 1 ? $clog2(G_MODULES_CONNECTED) : 1;
   logic [15:0] last_val [2**MW];
   logic [2**MW-1:0] seen;
   logic [MW-1:0] idx;
   logic [15:0] key;
   assign idx = cur_mod[MW-1:0];
   assign key = state == CNT2 ? {rec_data_o[23:16], fifo_data_i} : {fifo_data_i, 8'h00};
   assign drop = seen[idx] && last_val[idx] == key;
`else
   assign drop = 1'b0;
`endif
   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) begin
         state            <= ADDR;
         locked           <= 1'b0;
         expected_module  <= 8'd0;
         rec_valid_o      <= 1'b0;
         rec_data_o       <= 40'd0;
         sync_error_o     <= 1'b0;
         sync_error_cnt_o <= 16'd0;
`ifdef RAD_PACKER_CHANGE_FILTER_EN
         seen <= '0;
         for (int i = 0; i < 2**MW; i++) last_val[i] <= 16'd0;
`endif
      end else begin
         sync_error_o <= 1'b0;
         if (fifo_read_o && last_byte) begin
            locked          <= 1'b1;
            expected_module <= next_mod;
            rec_valid_o     <= !drop;
            state           <= drop ? ADDR : OUT;
         end
         case (state)
            ADDR: if (fifo_read_o) begin
               if (addr_ok) begin
                  rec_data_o[39:32] <= fifo_data_i;
                  state             <= VALUE;
               end else begin
                  locked       <= 1'b0;
                  sync_error_o <= 1'b1;
                  if (sync_error_cnt_o != 16'hFFFF) sync_error_cnt_o <= sync_error_cnt_o + 16'd1;
               end
            end
            VALUE: if (fifo_read_o) begin
               rec_data_o[31:24] <= fifo_data_i;
               state             <= CNT;
            end
            CNT: if (fifo_read_o) begin
               rec_data_o[23:16] <= fifo_data_i;
               if (TWO_MM) state <= VALUE2;
            end
            VALUE2: if (fifo_read_o) begin
               rec_data_o[15:8] <= fifo_data_i;
               state            <= CNT2;
            end
            CNT2: if (fifo_read_o) rec_data_o[7:0] <= fifo_data_i;
            OUT: if (rec_ready_i) begin
               rec_valid_o <= 1'b0;
               state       <= ADDR;
`ifdef RAD_PACKER_CHANGE_FILTER_EN
               seen[idx]     <= 1'b1;
               last_val[idx] <= {rec_data_o[23:16], rec_data_o[7:0]};
`endif
            end
            default: begin
               state       <= ADDR;
               locked      <= 1'b0;
               rec_valid_o <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_rad_monitor_record_packer.sv
// tb_rad_monitor_record_packer: table-driven records through a byte-FIFO model, scoreboard on the record output.
module tb_rad_monitor_record_packer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_read;
   logic [7:0]  fifo_data = 8'h00;
   logic        rec_valid;
   logic        rec_ready = 1'b0;
   logic [39:0] rec_data;
   logic        sync_error;
   logic [15:0] sync_error_cnt;

   always #5 clk = ~clk;

   rad_monitor_record_packer dut (
      .clk_i(clk), .rst_n_i(rst_n), .fifo_empty_i(fifo_empty), .fifo_read_o(fifo_read),
      .fifo_data_i(fifo_data), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
      .rec_data_o(rec_data), .sync_error_o(sync_error), .sync_error_cnt_o(sync_error_cnt)
   );

   typedef struct {
      int          n;
      logic [39:0] bytes;
      int          err;
   } vec_t;

   vec_t        tbl [7];
   logic [7:0]  bq [$];
   logic [39:0] sb [$];
   int n_chk = 0, n_fail = 0, exp_err = 0, pulses = 0, vcyc = 0, xfers = 0;
   bit gap = 1'b0, ready_en = 1'b1;
`ifdef RAD_PACKER_CHANGE_FILTER_EN
   bit          seen_m [256];
   logic [15:0] last_m [256];
`endif

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t rec(input logic [7:0] m, a, b, c, d);
      vec_t v;
      v.n = 5;
      v.bytes = {m, a, b, c, d};
      v.err = 0;
      return v;
   endfunction

   function automatic vec_t bad(input logic [7:0] m);
      vec_t v;
      v.n = 1;
      v.bytes = {m, 32'h0};
      v.err = 1;
      return v;
   endfunction

   task automatic send(input vec_t v);
      bit keep;
      for (int i = 0; i < v.n; i++) bq.push_back(v.bytes[39-8*i -: 8]);
      exp_err += v.err;
      if (v.n == 5) begin
         keep = 1'b1;
`ifdef RAD_PACKER_CHANGE_FILTER_EN
         if (seen_m[v.bytes[39:32]] && last_m[v.bytes[39:32]] == {v.bytes[23:16], v.bytes[7:0]}) keep = 1'b0;
         else begin
            seen_m[v.bytes[39:32]] = 1'b1;
            last_m[v.bytes[39:32]] = {v.bytes[23:16], v.bytes[7:0]};
         end
`endif
         if (keep) sb.push_back(v.bytes);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((bq.size() != 0 || sb.size() != 0) && t < 400) begin
         @(posedge clk);
         t++;
      end
      chk("drain_timeout", 40'(t >= 400), 40'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_errs();
      chk("err_cnt", 40'(sync_error_cnt), 40'(exp_err));
      chk("err_pulses", 40'(pulses), 40'(exp_err));
   endtask

   // FIFO model: first-word-fall-through head, popped when the DUT read at the previous edge
   initial begin
      bit took, tog;
      tog = 1'b0;
      forever begin
         @(posedge clk);
         took = fifo_read;
         @(negedge clk);
         if (took && bq.size() > 0) void'(bq.pop_front());
         tog = !tog;
         if (bq.size() == 0 || (gap && tog)) fifo_empty = 1'b1;
         else begin
            fifo_empty = 1'b0;
            fifo_data = bq[0];
         end
      end
   end

   // Output monitor: drives ready, scores transfers, checks hold and spacing rules
   initial begin
      logic pv, pxfer, xfer;
      logic [39:0] pd;
      pv = 1'b0; pxfer = 1'b0; pd = 40'd0;
      forever begin
         @(negedge clk);
         rec_ready = ready_en;
         #1;
         if (!rst_n) begin
            pv = 1'b0;
            pxfer = 1'b0;
         end else begin
            if (sync_error) pulses++;
            if (pxfer) chk("no_back_to_back", 40'(rec_valid), 40'd0);
            if (rec_valid) begin
               vcyc++;
               chk("no_read_in_out", 40'(fifo_read), 40'd0);
               if (pv && !pxfer) chk("data_hold", rec_data, pd);
            end
            xfer = rec_valid && rec_ready;
            if (xfer) begin
               xfers++;
               if (sb.size() == 0) chk("unexpected_record", rec_data, 40'd0 - 40'd1);
               else chk("record", rec_data, sb.pop_front());
            end
            pv = rec_valid;
            pd = rec_data;
            pxfer = xfer;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int xf0, t;
      logic [7:0] m, c, c2;
      tbl[0] = bad(8'h02);
      tbl[1] = rec(8'h03, 8'h44, 8'h05, 8'h55, 8'h06);
      tbl[2] = rec(8'h04, 8'h10, 8'hFF, 8'h20, 8'hFF);
      tbl[3] = rec(8'h00, 8'h12, 8'h00, 8'h21, 8'h00);
      tbl[4] = bad(8'h07);
      tbl[5] = bad(8'h05);
      tbl[6] = rec(8'h01, 8'h13, 8'h01, 8'h23, 8'h01);

      // reset behaviour with a byte already waiting at the FIFO head
      send(rec(8'h00, 8'h11, 8'h01, 8'h22, 8'h02));
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", 40'(rec_valid), 40'd0);
      chk("rst_data", rec_data, 40'd0);
      chk("rst_sync_err", 40'(sync_error), 40'd0);
      chk("rst_err_cnt", 40'(sync_error_cnt), 40'd0);
      chk("rst_read", 40'(fifo_read), 40'd0);
      vcyc = 0;
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk("sync_read_low", 40'(fifo_read), 40'd0);
      @(negedge clk);
      #1 chk("sync_read_high", 40'(fifo_read), 40'd1);
      drain();
      chk("valid_one_cycle", 40'(vcyc), 40'd1);
      check_errs();

      for (int i = 0; i < 7; i++) begin
         send(tbl[i]);
         drain();
         check_errs();
      end

      // backpressure with the next record already queued
      @(posedge clk);
      ready_en = 1'b0;
      send(rec(8'h02, 8'hAA, 8'h0B, 8'hBB, 8'h0C));
      send(rec(8'h03, 8'hCC, 8'h0D, 8'hDD, 8'h0E));
      t = 0;
      while (!rec_valid && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("stall_valid_timeout", 40'(t >= 100), 40'd0);
      repeat (10) @(negedge clk);
      #2;
      chk("stall_valid", 40'(rec_valid), 40'd1);
      chk("stall_fifo_untouched", 40'(bq.size()), 40'd5);
      chk("stall_pending", 40'(sb.size()), 40'd2);
      @(posedge clk);
      ready_en = 1'b1;
      drain();
      check_errs();

      // wrap through all modules with a gappy FIFO
      gap = 1'b1;
      for (int j = 0; j < 7; j++) begin
         m = 8'((4 + j) % 5);
         send(rec(m, 8'h50 + 8'(j), 8'(j), 8'h60 + 8'(j), 8'hF0 + 8'(j)));
      end
      drain();
      gap = 1'b0;
      check_errs();

      // module 3 counters 05,05,06 separated by full laps
      xf0 = xfers;
      for (int j = 0; j < 13; j++) begin
         m = 8'((1 + j) % 5);
         c = m == 8'd3 ? (j == 12 ? 8'h06 : 8'h05) : 8'h80 + 8'(j);
         c2 = m == 8'd3 ? 8'h09 : 8'h40 + 8'(j);
         send(rec(m, 8'h70 + 8'(j), c, 8'h30, c2));
      end
      drain();
`ifdef RAD_PACKER_CHANGE_FILTER_EN
      chk("filter_forwarded", 40'(xfers - xf0), 40'd12);
`else
      chk("filter_forwarded", 40'(xfers - xf0), 40'd13);
`endif
      check_errs();

      // reset after the third byte of a record
      send(rec(8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4));
      t = 0;
      while (bq.size() > 2 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("mid_wait_timeout", 40'(t >= 100), 40'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 40'(rec_valid), 40'd0);
      chk("mid_rst_data", rec_data, 40'd0);
      chk("mid_rst_err_cnt", 40'(sync_error_cnt), 40'd0);
      chk("mid_rst_read", 40'(fifo_read), 40'd0);
      bq.delete();
      sb.delete();
`ifdef RAD_PACKER_CHANGE_FILTER_EN
      for (int i = 0; i < 256; i++) begin
         seen_m[i] = 1'b0;
         last_m[i] = 16'h0;
      end
`endif
      exp_err = 0;
      pulses = 0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      send(bad(8'h05));
      send(rec(8'h04, 8'hB1, 8'hB2, 8'hB3, 8'hB4));
      send(rec(8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4));
      drain();
      check_errs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
